// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV32 core. Absorbs fixed IMEM/DMEM latencies.
// Optional single-step gate: compile with `define SINGLE_STEP_EN.
module riscv_multicycle_sequencer #(
   parameter int unsigned IMEM_LAT     = 0,
   parameter int unsigned DMEM_LAT     = 0,
   parameter int unsigned FENCE_CYCLES = 2,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 run_en,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic                 is_fence,
   input  logic                 is_system,
   input  logic                 pc_halt,
   input  logic                 rd_wr,
   input  logic [3:0]           decoder_dmem_we,
   input  logic                 step_mode,
   input  logic                 step,
   output logic                 pc_we,
   output logic                 imem_rd,
   output logic                 rf_we,
   output logic                 dmem_rd,
   output logic [3:0]           dmem_we,
   output logic                 halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instret_count
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_FWAIT = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_MWAIT = 3'd4,
      S_FENCE = 3'd5,
      S_WB    = 3'd6,
      S_HALT  = 3'd7
   } state_e;

   // The wait counter counts down to zero, so it is loaded with LAT-1 on entry.
   localparam logic [3:0] IMEM_RELOAD  = (IMEM_LAT > 0) ? 4'(IMEM_LAT - 1) : 4'd0;
   localparam logic [3:0] DMEM_RELOAD  = (DMEM_LAT > 0) ? 4'(DMEM_LAT - 1) : 4'd0;
   localparam logic [3:0] FENCE_RELOAD = (FENCE_CYCLES > 0) ? 4'(FENCE_CYCLES - 1) : 4'd0;

   state_e               state_q, state_d;
   logic [3:0]           wait_q, wait_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_WIDTH-1:0] instret_count_q, instret_count_d;
   logic                 fetch_ok;

`ifdef SINGLE_STEP_EN
   logic [2:0] step_sync_q, step_sync_d;
   logic       step_edge;

   always_comb begin
      step_sync_d = {step_sync_q[1:0], step};
      step_edge   = step_sync_q[1] & ~step_sync_q[2];
      fetch_ok    = rstn & run_en & (~step_mode | step_edge);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) step_sync_q <= '0;
      else       step_sync_q <= step_sync_d;
   end
`else
   logic unused_step;

   always_comb begin
      unused_step = step_mode ^ step;
      fetch_ok    = rstn & run_en;
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_FETCH: begin
            if (fetch_ok) begin
               if (IMEM_LAT > 0) begin
                  state_d = S_FWAIT;
                  wait_d  = IMEM_RELOAD;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_FWAIT: begin
            if (wait_q == '0) state_d = S_EXEC;
            else              wait_d  = wait_q - 4'd1;
         end
         S_EXEC: begin
            if (is_system | pc_halt) begin
               state_d = S_HALT;
            end else if (is_load | is_store) begin
               state_d = S_MEM;
            end else if (is_fence) begin
               state_d = S_FENCE;
               wait_d  = FENCE_RELOAD;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (DMEM_LAT > 0) begin
               state_d = S_MWAIT;
               wait_d  = DMEM_RELOAD;
            end else begin
               state_d = S_WB;
            end
         end
         S_MWAIT, S_FENCE: begin
            if (wait_q == '0) state_d = S_WB;
            else              wait_d  = wait_q - 4'd1;
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we   = 1'b0;
      imem_rd = 1'b0;
      rf_we   = 1'b0;
      dmem_rd = 1'b0;
      dmem_we = '0;
      halted  = 1'b0;
      case (state_q)
         S_FETCH: imem_rd = fetch_ok;
         S_MEM: begin
            dmem_rd = is_load;
            dmem_we = (is_store & ~is_load) ? decoder_dmem_we : 4'b0000;
         end
         S_WB: begin
            pc_we = 1'b1;
            rf_we = rd_wr & ~is_fence & ~(is_store & ~is_load);
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cycle_count_d   = (state_q != S_HALT) ? cycle_count_q + CNT_WIDTH'(1) : cycle_count_q;
      instret_count_d = (state_q == S_WB) ? instret_count_q + CNT_WIDTH'(1) : instret_count_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_count_q   <= '0;
         instret_count_q <= '0;
      end else begin
         cycle_count_q   <= cycle_count_d;
         instret_count_q <= instret_count_d;
      end
   end

   assign state         = state_q;
   assign cycle_count   = cycle_count_q;
   assign instret_count = instret_count_q;

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// Self-checking bench for riscv_multicycle_sequencer: two configurations, randomized instruction mix,
// reference timeline built per instruction class from the latency parameters.
module tb_riscv_multicycle_sequencer;

   localparam int IL0 = 0, DL0 = 0, FC0 = 2;
   localparam int IL1 = 2, DL1 = 3, FC1 = 3;

   logic       clk = 1'b0;
   logic       rstn0 = 1'b0, rstn1 = 1'b0;
   logic       run_en = 1'b0, is_load = 1'b0, is_store = 1'b0, is_fence = 1'b0;
   logic       is_system = 1'b0, pc_halt = 1'b0, rd_wr = 1'b0;
   logic [3:0] decoder_dmem_we = 4'h0;
   logic       step_mode = 1'b0, step = 1'b0;

   logic        pc_we0, imem_rd0, rf_we0, dmem_rd0, halted0;
   logic [3:0]  dmem_we0;
   logic [2:0]  state0;
   logic [31:0] cyc0, ret0;
   logic        pc_we1, imem_rd1, rf_we1, dmem_rd1, halted1;
   logic [3:0]  dmem_we1;
   logic [2:0]  state1;
   logic [7:0]  cyc1, ret1;

   riscv_multicycle_sequencer #(.IMEM_LAT(IL0), .DMEM_LAT(DL0), .FENCE_CYCLES(FC0), .CNT_WIDTH(32)) u0 (
      .clk(clk), .rstn(rstn0), .run_en(run_en), .is_load(is_load), .is_store(is_store),
      .is_fence(is_fence), .is_system(is_system), .pc_halt(pc_halt), .rd_wr(rd_wr),
      .decoder_dmem_we(decoder_dmem_we), .step_mode(step_mode), .step(step),
      .pc_we(pc_we0), .imem_rd(imem_rd0), .rf_we(rf_we0), .dmem_rd(dmem_rd0), .dmem_we(dmem_we0),
      .halted(halted0), .state(state0), .cycle_count(cyc0), .instret_count(ret0));

   riscv_multicycle_sequencer #(.IMEM_LAT(IL1), .DMEM_LAT(DL1), .FENCE_CYCLES(FC1), .CNT_WIDTH(8)) u1 (
      .clk(clk), .rstn(rstn1), .run_en(run_en), .is_load(is_load), .is_store(is_store),
      .is_fence(is_fence), .is_system(is_system), .pc_halt(pc_halt), .rd_wr(rd_wr),
      .decoder_dmem_we(decoder_dmem_we), .step_mode(step_mode), .step(step),
      .pc_we(pc_we1), .imem_rd(imem_rd1), .rf_we(rf_we1), .dmem_rd(dmem_rd1), .dmem_we(dmem_we1),
      .halted(halted1), .state(state1), .cycle_count(cyc1), .instret_count(ret1));

   always #5 clk = ~clk;

   int              n_vec = 0;
   int              n_err = 0;
   int              sel = 0;
   longint unsigned exp_cyc = 0;
   longint unsigned exp_ret = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] obs();
      if (sel == 0) return {halted0, state0, pc_we0, imem_rd0, rf_we0, dmem_rd0, dmem_we0};
      return {halted1, state1, pc_we1, imem_rd1, rf_we1, dmem_rd1, dmem_we1};
   endfunction

   function automatic logic [63:0] obs_cyc();
      return (sel == 0) ? {32'h0, cyc0} : {56'h0, cyc1};
   endfunction

   function automatic logic [63:0] obs_ret();
      return (sel == 0) ? {32'h0, ret0} : {56'h0, ret1};
   endfunction

   function automatic logic [63:0] cmask();
      return (sel == 0) ? 64'hFFFF_FFFF : 64'hFF;
   endfunction

   // Expected output bundle for one cycle spent in state st
   function automatic logic [12:0] mk(input int st, input bit go, input bit rfv, input bit ld,
                                      input logic [3:0] dw);
      logic [2:0] s;
      s = 3'(st);
      return {st == 7, s, st == 6, (st == 0) && go, (st == 6) && rfv, (st == 3) && ld,
              (st == 3) ? dw : 4'h0};
   endfunction

   // cls: 0 alu, 1 load, 2 store, 3 fence, 4 load+store, 5 system
   task automatic run_instr(input int cls, input bit rdw, input logic [3:0] m, input bit hp,
                            input int abort_at);
      int tl[$];
      int il, dl, fc;
      bit ld, stq, rfv;
      il  = (sel == 0) ? IL0 : IL1;
      dl  = (sel == 0) ? DL0 : DL1;
      fc  = (sel == 0) ? FC0 : FC1;
      ld  = (cls == 1) || (cls == 4);
      stq = (cls == 2) || (cls == 4);
      rfv = rdw && (cls != 3) && !(stq && !ld);
      is_load = ld; is_store = stq; is_fence = (cls == 3); is_system = (cls == 5);
      pc_halt = hp; rd_wr = rdw; decoder_dmem_we = m; run_en = 1'b1;
      tl.push_back(0);
      repeat (il) tl.push_back(1);
      tl.push_back(2);
      if (cls == 5 || hp) begin
         tl.push_back(7);
      end else begin
         if (ld || stq) begin
            tl.push_back(3);
            repeat (dl) tl.push_back(4);
         end else if (cls == 3) begin
            repeat (fc) tl.push_back(5);
         end
         tl.push_back(6);
      end
      #1;
      foreach (tl[k]) begin
         check_val("seq", obs(), mk(tl[k], 1'b1, rfv, ld, (stq && !ld) ? m : 4'h0));
         if (k == abort_at) begin
            if (sel == 0) rstn0 = 1'b0; else rstn1 = 1'b0;
            #1;
            check_val("abort_out", obs(), 64'h0);
            check_val("abort_cyc", obs_cyc(), 64'h0);
            check_val("abort_ret", obs_ret(), 64'h0);
            exp_cyc = 0;
            exp_ret = 0;
            @(negedge clk); #1;
            if (sel == 0) rstn0 = 1'b1; else rstn1 = 1'b1;
            return;
         end
         if (tl[k] == 7) return;
         @(negedge clk); #1;
         exp_cyc++;
         if (tl[k] == 6) exp_ret++;
      end
      check_val("cycles", obs_cyc(), exp_cyc & cmask());
      check_val("instret", obs_ret(), exp_ret & cmask());
   endtask

   task automatic stall(input int n);
      run_en = 1'b0;
      repeat (n) begin
         #1;
         check_val("stall", obs(), mk(0, 1'b0, 1'b0, 1'b0, 4'h0));
         @(negedge clk); #1;
         exp_cyc++;
      end
   endtask

   task automatic halt_hold(input int n);
      repeat (n) begin
         run_en = 1'($urandom_range(0, 1));
         #1;
         check_val("halt", obs(), mk(7, 1'b0, 1'b0, 1'b0, 4'h0));
         check_val("halt_cyc", obs_cyc(), exp_cyc & cmask());
         check_val("halt_ret", obs_ret(), exp_ret & cmask());
         @(negedge clk); #1;
      end
   endtask

   task automatic rand_instr();
      stall($urandom_range(0, 2));
      run_instr($urandom_range(0, 4), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 1'b0, -1);
   endtask

   task automatic reset_pulse();
      if (sel == 0) rstn0 = 1'b0; else rstn1 = 1'b0;
      #1;
      check_val("rst_out", obs(), 64'h0);
      check_val("rst_cyc", obs_cyc(), 64'h0);
      check_val("rst_ret", obs_ret(), 64'h0);
      exp_cyc = 0;
      exp_ret = 0;
      @(negedge clk); #1;
      if (sel == 0) rstn0 = 1'b1; else rstn1 = 1'b1;
   endtask

`ifdef SINGLE_STEP_EN
   task automatic step_run(input int cycles, input bit hold, input int exp_n);
      int seen;
      seen = 0;
      is_load = 1'b0; is_store = 1'b0; is_fence = 1'b0; is_system = 1'b0; pc_halt = 1'b0;
      rd_wr = 1'b1; run_en = 1'b1; step_mode = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         step = hold ? 1'b1 : ((c < 30) && ((c % 10) < 4));
         #1;
         if (pc_we0) seen++;
         @(negedge clk); #1;
         exp_cyc++;
      end
      step = 1'b0;
      exp_ret += longint'(exp_n);
      check_val("step_retire", 64'(seen), 64'(exp_n));
      check_val("step_cycles", obs_cyc(), exp_cyc & cmask());
      check_val("step_instret", obs_ret(), exp_ret & cmask());
      step_mode = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      sel = 0;
      run_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst0", obs(), 64'h0);
      check_val("rst0_cyc", obs_cyc(), 64'h0);
      check_val("rst0_ret", obs_ret(), 64'h0);
      rstn0 = 1'b1;

      run_instr(0, 1'b1, 4'h0, 1'b0, -1);
`ifdef SINGLE_STEP_EN
      step_run(40, 1'b0, 3);
      step_run(30, 1'b1, 1);
`else
      step_mode = 1'b1;
      run_instr(0, 1'b1, 4'h0, 1'b0, -1);
      step_mode = 1'b0;
`endif
      repeat (30) rand_instr();
      reset_pulse();
      repeat (5) rand_instr();
      run_instr(5, 1'b1, 4'h0, 1'b0, -1);
      halt_hold(20);
      rstn0 = 1'b0;
      #1;
      check_val("rst_from_halt", obs(), 64'h0);

      sel = 1;
      exp_cyc = 0;
      exp_ret = 0;
      @(negedge clk); #1;
      rstn1 = 1'b1;
      run_instr(1, 1'b1, 4'h0, 1'b0, -1);
      run_instr(2, 1'b1, 4'b0100, 1'b0, -1);
      run_instr(1, 1'b1, 4'h0, 1'b0, 6);
      run_instr(0, 1'b1, 4'h0, 1'b0, -1);
      repeat (60) rand_instr();
      run_instr(0, 1'b1, 4'h0, 1'b1, -1);
      halt_hold(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_sequencer.md
Name: riscv_multicycle_sequencer

Overview:
- Parametrised multi-cycle successor to the single-cycle core control unit.
- Sequences FETCH / EXEC / MEM / WB for the RV32 datapath, absorbing fixed instruction-memory and data-memory latencies set by parameters.
- Adds a FENCE drain, a sticky HALT state, a run gate and cycle/instret performance counters.
- Sits between the decoder outputs and the PC / IMEM / register-file / DMEM strobes in the core wrapper.

Parameters:
- IMEM_LAT, 0, extra wait cycles after the imem_rd strobe before the instruction is valid (0..15).
- DMEM_LAT, 0, extra wait cycles after the dmem_rd / dmem_we strobe before load data is valid (0..15).
- FENCE_CYCLES, 2, drain cycles spent for a FENCE instruction (1..15).
- CNT_WIDTH, 32, width of the cycle_count and instret_count counters.

Ports:
- clk  in  1  core clock
- rstn  in  1  reset; asynchronous, active-low
- run_en  in  1  high lets the sequencer leave FETCH; low holds it in FETCH
- is_load  in  1  decoded LOAD
- is_store  in  1  decoded STORE
- is_fence  in  1  decoded FENCE
- is_system  in  1  decoded SYSTEM
- pc_halt  in  1  PC reports end of program
- rd_wr  in  1  decoded instruction writes rd (LUI/AUIPC/JAL/JALR/IMM/ALU/LOAD)
- decoder_dmem_we  in  4  byte-enable mask from the decoder for stores
- step_mode  in  1  single-step enable (see Optional Feature)
- step  in  1  single-step request, level from a debounced button
- pc_we  out  1  PC update strobe
- imem_rd  out  1  instruction-fetch strobe
- rf_we  out  1  register-file write strobe
- dmem_rd  out  1  data-memory read strobe
- dmem_we  out  4  data-memory byte write enables
- halted  out  1  sequencer is in HALT
- state  out  3  current state encoding, for debug/LED
- cycle_count  out  CNT_WIDTH  cycles spent outside HALT
- instret_count  out  CNT_WIDTH  retired instructions

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=FETCH (0); all strobes 0; halted=0; both counters 0.
- State encoding: FETCH=0, FWAIT=1, EXEC=2, MEM=3, MWAIT=4, FENCE=5, WB=6, HALT=7.
- Only one state issues each strobe, each for exactly one cycle per instruction.
- FETCH:
  - If run_en=0 (or the single-step gate is closed): hold, imem_rd=0.
  - Otherwise imem_rd=1 for one cycle; next state is FWAIT if IMEM_LAT>0, else EXEC.
- FWAIT: wait-counter runs IMEM_LAT cycles, then EXEC.
- EXEC (instruction stable, no strobes), priority order:
  - is_system or pc_halt -> HALT
  - else is_load or is_store -> MEM
  - else is_fence -> FENCE
  - else -> WB
- MEM:
  - Load: dmem_rd=1.
  - Store: dmem_we=decoder_dmem_we.
  - Both asserted together: load wins, dmem_we=0.
  - Next state is MWAIT if DMEM_LAT>0, else WB.
- MWAIT: DMEM_LAT cycles, then WB.
- FENCE: FENCE_CYCLES cycles, then WB.
- WB:
  - pc_we=1; rf_we=rd_wr, forced to 0 for stores and FENCE.
  - instret_count increments; next state FETCH.
- HALT:
  - halted=1, all strobes 0, counters frozen.
  - Exit only via reset; run_en is ignored.
- Latency with zero latency parameters:
  - ALU/branch/jump: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each latency parameter adds exactly its value in cycles.
- dmem_we is 0 in every state except MEM.
- The wait counter is a single shared 4-bit down-counter, reloaded on entry to each wait state.
- cycle_count increments every cycle while state≠HALT, including FETCH stalled by run_en=0.
- Both counters wrap modulo 2^CNT_WIDTH with no saturation.
- rstn assertion mid-instruction (any state, including wait states) aborts immediately to the reset values; a partially waited memory access is not replayed.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - step is passed through a 2-flop synchroniser plus rising-edge detect.
  - With step_mode=1, FETCH proceeds only in a cycle where a step edge is seen (and run_en=1); exactly one instruction executes per edge.
  - Edges arriving outside FETCH are discarded.
  - With step_mode=0, behaviour matches the undefined case.
- Undefined: step_mode and step are ignored; no synchroniser flops are present.

Test Plan:
- ADD with IMEM_LAT=0, DMEM_LAT=0, rd_wr=1, run_en=1:
  - imem_rd at cycle 0, rf_we and pc_we together at cycle 2, instret_count=1 at cycle 3.
- LW with IMEM_LAT=2, DMEM_LAT=3:
  - imem_rd at cycle 0, dmem_rd at cycle 4, rf_we/pc_we at cycle 8, dmem_we=0 throughout.
- SB with decoder_dmem_we=4'b0100:
  - dmem_we=4'b0100 for exactly one cycle in MEM; rf_we=0 even if rd_wr=1.
- ECALL (is_system=1) after 5 retired instructions:
  - halted=1, state=7; instret_count stays 5; cycle_count frozen for 20 more cycles; run_en toggling has no effect.
- Reset during MWAIT (DMEM_LAT=5, rstn low at wait cycle 2):
  - All outputs zero within the same cycle, state=0.
  - After release, the next imem_rd occurs on the first cycle.
- SINGLE_STEP_EN defined, step_mode=1:
  - Three step pulses, each 4 cycles wide and 10 cycles apart -> exactly 3 instructions retire; step held high gives no repeat.
